pacoblaze_register_banked: RTL and testbench
============================================

Name: pacoblaze_register_banked

Overview:
- Parametrised successor to the PacoBlaze register file.
- Holds 2^BANK_BITS register banks, each 2^DEPTH_BITS words of WIDTH bits.
- Provides two asynchronous read ports (x, y) and one synchronous write port (x), all addressing the active bank.
- Adds a bank-select register and a post-reset clear sequencer, so every register reads zero after reset.
- Sits between the PacoBlaze decode/ALU datapath and the core's register storage.

Parameters:
- WIDTH, 8, register data width in bits.
- DEPTH_BITS, 4, address bits per bank (16 registers per bank).
- BANK_BITS, 1, bank-select bits (2 banks). Must be at least 1.
- Derived: TOTAL = 2^(DEPTH_BITS+BANK_BITS) words.

Ports:
- clk  in  1  system clock; rising edge active.
- reset  in  1  asynchronous, active-high reset.
- bank_write_enable  in  1  load bank_in into the bank-select register.
- bank_in  in  BANK_BITS  new active bank.
- bank  out  BANK_BITS  current active bank.
- busy  out  1  high while the clear sequencer runs.
- x_address  in  DEPTH_BITS  read/write address within the active bank.
- x_write_enable  in  1  write x_data_in at the next rising edge.
- x_data_in  in  WIDTH  write data.
- x_data_out  out  WIDTH  combinational read of {bank, x_address}.
- y_address  in  DEPTH_BITS  second read address within the active bank.
- y_data_out  out  WIDTH  combinational read of {bank, y_address}.

Behaviour:
- Clock and reset (already decided): single clock clk; reset is asynchronous and active-high.
- Storage: flat array of TOTAL words. Flat index = {bank, address}, bank in the MSBs.
- Reset asserted:
  - state = CLEAR, clr_ptr = 0, bank = 0, busy = 1.
  - The array itself is not reset.
- State CLEAR:
  - Each rising edge writes 0 to array[clr_ptr] and increments clr_ptr.
  - The edge that writes array[TOTAL-1] moves to RUN; busy = 0 from that edge on.
  - busy is high for exactly TOTAL cycles after reset deasserts (32 cycles at defaults).
  - x_write_enable and bank_write_enable are ignored.
  - x_data_out and y_data_out are forced to 0.
- State RUN:
  - x_write_enable = 1: array[{bank, x_address}] <= x_data_in at the rising edge.
  - bank_write_enable = 1: bank <= bank_in at the rising edge.
  - Outputs read the array combinationally with zero latency.
  - RUN is left only via reset.
- Simultaneous write and bank switch in one cycle: the write targets the bank in effect before the edge (old bank). Reads after the edge use the new bank.
- Read during write to the same address (no bypass): outputs show the old value until the edge, then the new value.
- x_address == y_address: both outputs are identical.
- Reset mid-CLEAR or mid-RUN: the sequencer restarts from clr_ptr = 0 and the whole array is re-cleared. Contents present before reset are not guaranteed.
- clr_ptr is (DEPTH_BITS+BANK_BITS) bits wide. Wrap-around never occurs because the sequencer leaves CLEAR at TOTAL-1.

Optional Feature:
- Macro: PACOBLAZE_REGISTER_BYPASS_EN.
- Defined, in RUN: if x_write_enable = 1 and the read address equals x_address, that output returns x_data_in combinationally in the same cycle (write-first). This applies independently to x_data_out and y_data_out, matching against the current bank.
- Defined, in CLEAR: no bypass; outputs stay 0.
- Not defined: no bypass logic; reads return stored contents only (read-first).

Test Plan:
- Reset clear (defaults):
  - Pulse reset, then count cycles: busy = 1 for exactly 32 cycles, then 0; bank = 0.
  - Every {bank, address} then reads 0x00 on both ports, including after pre-reset writes of 0xFF.
- Write/readback: bank 0, write 0x5A to r3 and 0xA5 to r15; x_address = 3 -> 0x5A; y_address = 15 -> 0xA5, same cycle.
- Bank isolation: write 0x11 to bank0 r2; switch to bank 1; read r2 -> 0x00; write 0x22; switch back; read r2 -> 0x11.
- Simultaneous write and bank switch: in bank 0, set x_write_enable = 1 (r7, 0x77) and bank_write_enable = 1 (bank_in = 1) in one cycle -> bank = 1, bank1 r7 = 0x00, bank0 r7 = 0x77.
- Busy lockout and mid-operation reset:
  - Assert write and bank select during CLEAR: no effect; after busy falls, all reads 0, bank = 0.
  - Assert reset in RUN: busy rises immediately; after 32 cycles, prior data reads 0.
- Bypass (macro defined): write 0x3C to r4 with x_address = y_address = 4 -> both outputs 0x3C in the same cycle. Without the macro -> old value, then 0x3C after the edge.

Source files
------------

// File: rtl/pacoblaze_register_banked.sv
`default_nettype none
// ============================================================================
// Module      : pacoblaze_register_banked
// Description : Banked register file for the PacoBlaze core. Holds
//               2^BANK_BITS banks of 2^DEPTH_BITS words, each WIDTH bits.
//               Two combinational read ports (x, y) and one synchronous write
//               port (x), all addressing the active bank. A bank-select
//               register picks the active bank. After reset a clear sequencer
//               zeroes every word (busy high) before normal operation.
//
//               Ports:
//                 clk               system clock, rising edge
//                 reset             asynchronous, active-high reset
//                 bank_write_enable load bank_in into the bank register
//                 bank_in / bank    new / current active bank
//                 busy              high while the clear sequencer runs
//                 x_address         read/write address in the active bank
//                 x_write_enable    write x_data_in at the next edge
//                 x_data_in         write data
//                 x_data_out        combinational read of {bank, x_address}
//                 y_address         second read address in the active bank
//                 y_data_out        combinational read of {bank, y_address}
//
//               Optional macro PACOBLAZE_REGISTER_BYPASS_EN: when defined,
//               a read of the address being written returns x_data_in in the
//               same cycle (write-first). Undefined: read-first.
// Revision    : 1.0 - initial release
// ============================================================================
module pacoblaze_register_banked #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4,
    parameter int BANK_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bank_write_enable,
    input  logic [BANK_BITS-1:0]  bank_in,
    output logic [BANK_BITS-1:0]  bank,
    output logic                  busy,
    input  logic [DEPTH_BITS-1:0] x_address,
    input  logic                  x_write_enable,
    input  logic [WIDTH-1:0]      x_data_in,
    output logic [WIDTH-1:0]      x_data_out,
    input  logic [DEPTH_BITS-1:0] y_address,
    output logic [WIDTH-1:0]      y_data_out
);

    localparam int c_AW    = DEPTH_BITS + BANK_BITS;
    localparam int c_TOTAL = 1 << c_AW;

    localparam logic [c_AW-1:0] c_CLR_LAST = {c_AW{1'b1}};

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_AW-1:0]      r_clr_ptr;
    logic [c_AW-1:0]      w_clr_ptr_nxt;
    logic [BANK_BITS-1:0] r_bank;
    logic [BANK_BITS-1:0] w_bank_nxt;

    // Storage is deliberately not reset; the clear sequencer zeroes it.
    logic [WIDTH-1:0]     r_mem [c_TOTAL];

    logic                 w_mem_we;
    logic [c_AW-1:0]      w_mem_addr;
    logic [WIDTH-1:0]     w_mem_data;

    logic                 w_clearing;
    logic [WIDTH-1:0]     w_x_rd;
    logic [WIDTH-1:0]     w_y_rd;

    assign w_clearing = (r_state == c_ST_CLEAR);

    // ------------------------------------------------------------------------
    // Next-state logic: the clear sequence and run-time writes share the
    // single memory write port.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_bank_nxt    = r_bank;
        w_mem_we      = 1'b0;
        w_mem_addr    = {r_bank, x_address};
        w_mem_data    = x_data_in;

        case (r_state)
            c_ST_CLEAR: begin
                // Writes and bank selects from the datapath are ignored here.
                w_mem_we      = 1'b1;
                w_mem_addr    = r_clr_ptr;
                w_mem_data    = '0;
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_CLR_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                // The write address uses r_bank, so a simultaneous bank
                // switch still lands the write in the old bank.
                w_mem_we = x_write_enable;
                if (bank_write_enable) begin
                    w_bank_nxt = bank_in;
                end
            end
            default: begin
                w_state_nxt = c_ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_CLEAR;
            r_clr_ptr <= '0;
            r_bank    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_bank    <= w_bank_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
`ifdef PACOBLAZE_REGISTER_BYPASS_EN
    // Write-first: forward the pending write to any port reading its address.
    assign w_x_rd = x_write_enable ? x_data_in : r_mem[{r_bank, x_address}];
    assign w_y_rd = (x_write_enable && (y_address == x_address))
                    ? x_data_in : r_mem[{r_bank, y_address}];
`else
    assign w_x_rd = r_mem[{r_bank, x_address}];
    assign w_y_rd = r_mem[{r_bank, y_address}];
`endif

    // Contents are undefined until cleared, so mask reads while clearing.
    assign x_data_out = w_clearing ? '0 : w_x_rd;
    assign y_data_out = w_clearing ? '0 : w_y_rd;
    assign bank       = r_bank;
    assign busy       = w_clearing;

endmodule
`default_nettype wire

// File: tb/tb_pacoblaze_register_banked.sv
`default_nettype none
// ============================================================================
// Module      : tb_pacoblaze_register_banked
// Description : Self-checking bench for pacoblaze_register_banked. A
//               behavioural model (plain array, bank number and a count of
//               remaining clear cycles) predicts busy, bank and both read
//               ports on every cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pacoblaze_register_banked;

    localparam int WIDTH      = 8;
    localparam int DEPTH_BITS = 4;
    localparam int BANK_BITS  = 1;
    localparam int DEPTH      = 1 << DEPTH_BITS;
    localparam int TOTAL      = 1 << (DEPTH_BITS + BANK_BITS);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  bank_write_enable;
    logic [BANK_BITS-1:0]  bank_in;
    logic [BANK_BITS-1:0]  bank;
    logic                  busy;
    logic [DEPTH_BITS-1:0] x_address;
    logic                  x_write_enable;
    logic [WIDTH-1:0]      x_data_in;
    logic [WIDTH-1:0]      x_data_out;
    logic [DEPTH_BITS-1:0] y_address;
    logic [WIDTH-1:0]      y_data_out;

    pacoblaze_register_banked #(
        .WIDTH      (WIDTH),
        .DEPTH_BITS (DEPTH_BITS),
        .BANK_BITS  (BANK_BITS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bank_write_enable (bank_write_enable),
        .bank_in           (bank_in),
        .bank              (bank),
        .busy              (busy),
        .x_address         (x_address),
        .x_write_enable    (x_write_enable),
        .x_data_in         (x_data_in),
        .x_data_out        (x_data_out),
        .y_address         (y_address),
        .y_data_out        (y_data_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] m_mem [TOTAL];
    int               m_bank       = 0;
    int               m_clear_left = TOTAL;

    initial begin
        foreach (m_mem[i]) m_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_clear_left = TOTAL;
            m_bank       = 0;
        end else if (m_clear_left > 0) begin
            m_clear_left--;
            if (m_clear_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            if (x_write_enable) m_mem[m_bank * DEPTH + int'(x_address)] = x_data_in;
            if (bank_write_enable) m_bank = int'(bank_in);
        end
    end

    function automatic logic exp_busy();
        return reset || (m_clear_left > 0);
    endfunction

    function automatic logic [WIDTH-1:0] exp_rd(input logic [DEPTH_BITS-1:0] a);
        if (exp_busy()) return '0;
`ifdef PACOBLAZE_REGISTER_BYPASS_EN
        if (x_write_enable && (a == x_address)) return x_data_in;
`endif
        return m_mem[m_bank * DEPTH + int'(a)];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(exp_busy()));
            check("bank", 32'(bank), reset ? 32'd0 : 32'(m_bank));
            check("x_data_out", 32'(x_data_out), 32'(exp_rd(x_address)));
            check("y_data_out", 32'(y_data_out), 32'(exp_rd(y_address)));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------------
    task automatic drive(input logic we, input logic [DEPTH_BITS-1:0] xa,
                         input logic [WIDTH-1:0] d, input logic [DEPTH_BITS-1:0] ya,
                         input logic bwe, input logic [BANK_BITS-1:0] bin);
        @(posedge clk);
        #1;
        x_write_enable    = we;
        x_address         = xa;
        x_data_in         = d;
        y_address         = ya;
        bank_write_enable = bwe;
        bank_in           = bin;
    endtask

    task automatic wr(input logic [DEPTH_BITS-1:0] a, input logic [WIDTH-1:0] d);
        drive(1'b1, a, d, a, 1'b0, '0);
    endtask

    task automatic set_bank(input logic [BANK_BITS-1:0] b);
        drive(1'b0, '0, '0, '0, 1'b1, b);
    endtask

    task automatic read_chk(input string name, input logic [DEPTH_BITS-1:0] xa,
                            input logic [DEPTH_BITS-1:0] ya,
                            input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] ey);
        drive(1'b0, xa, '0, ya, 1'b0, '0);
        @(negedge clk);
        check({name, "_x"}, 32'(x_data_out), 32'(ex));
        check({name, "_y"}, 32'(y_data_out), 32'(ey));
    endtask

    // Called one unit after the edge that releases reset; counts busy cycles.
    task automatic wait_clear(input string name);
        int cnt = 0;
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        while (busy === 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        x_write_enable    = 1'b0;
        bank_write_enable = 1'b0;
        bank_in           = '0;
        check({name, "_busy_cycles"}, 32'(cnt), 32'(TOTAL));
        check({name, "_bank"}, 32'(bank), 32'd0);
    endtask

    task automatic read_all_zero(input string name);
        for (int b = 0; b < (1 << BANK_BITS); b++) begin
            set_bank(BANK_BITS'(b));
            for (int a = 0; a < DEPTH; a++) begin
                read_chk(name, DEPTH_BITS'(a), DEPTH_BITS'(DEPTH - 1 - a), 8'h00, 8'h00);
            end
        end
        set_bank('0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        reset             = 1'b1;
        bank_write_enable = 1'b0;
        bank_in           = '0;
        x_address         = '0;
        x_write_enable    = 1'b0;
        x_data_in         = '0;
        y_address         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        // Writes and bank selects held during the clear must be ignored.
        x_write_enable    = 1'b1;
        x_address         = 4'd5;
        x_data_in         = 8'hFF;
        bank_write_enable = 1'b1;
        bank_in           = 1'b1;
        wait_clear("clear1");
        read_all_zero("zero1");

        // Fill everything with 0xFF, then reset in RUN.
        for (int b = 0; b < (1 << BANK_BITS); b++) begin
            set_bank(BANK_BITS'(b));
            for (int a = 0; a < DEPTH; a++) wr(DEPTH_BITS'(a), 8'hFF);
        end
        set_bank('0);
        read_chk("filled", 4'd0, 4'd1, 8'hFF, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("busy_on_reset", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_clear("clear2");
        read_all_zero("zero2");

        // Write / readback on both ports in the same cycle.
        wr(4'd3, 8'h5A);
        wr(4'd15, 8'hA5);
        read_chk("wr_rb", 4'd3, 4'd15, 8'h5A, 8'hA5);

        // Bank isolation.
        wr(4'd2, 8'h11);
        set_bank(1'b1);
        read_chk("iso_b1_empty", 4'd2, 4'd2, 8'h00, 8'h00);
        wr(4'd2, 8'h22);
        read_chk("iso_b1", 4'd2, 4'd2, 8'h22, 8'h22);
        set_bank(1'b0);
        read_chk("iso_b0", 4'd2, 4'd2, 8'h11, 8'h11);

        // Write and bank switch in the same cycle: write goes to old bank.
        drive(1'b1, 4'd7, 8'h77, 4'd7, 1'b1, 1'b1);
        read_chk("simul_b1", 4'd7, 4'd7, 8'h00, 8'h00);
        check("simul_bank", 32'(bank), 32'd1);
        set_bank(1'b0);
        read_chk("simul_b0", 4'd7, 4'd7, 8'h77, 8'h77);

        // Read during write of the same address.
        read_chk("bypass_pre", 4'd4, 4'd4, 8'h00, 8'h00);
        drive(1'b1, 4'd4, 8'h3C, 4'd4, 1'b0, '0);
        @(negedge clk);
`ifdef PACOBLAZE_REGISTER_BYPASS_EN
        check("bypass_same_x", 32'(x_data_out), 32'h3C);
        check("bypass_same_y", 32'(y_data_out), 32'h3C);
`else
        check("readfirst_same_x", 32'(x_data_out), 32'h00);
        check("readfirst_same_y", 32'(y_data_out), 32'h00);
`endif
        read_chk("bypass_post", 4'd4, 4'd4, 8'h3C, 8'h3C);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (reset) reset = 1'b0;
            else       reset = ($urandom_range(0, 299) == 0);
            x_write_enable    = $urandom_range(0, 1) == 1;
            x_address         = DEPTH_BITS'($urandom);
            x_data_in         = WIDTH'($urandom);
            y_address         = ($urandom_range(0, 3) == 0) ? x_address : DEPTH_BITS'($urandom);
            bank_write_enable = ($urandom_range(0, 7) == 0);
            bank_in           = BANK_BITS'($urandom);
        end
        @(posedge clk);
        #1;
        reset             = 1'b0;
        x_write_enable    = 1'b0;
        bank_write_enable = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
